// File: rtl/au_decimator.sv
// Integrate-and-dump audio decimator: sums N samples, shifts, saturates, emits one output per group.
// Stage 1 accumulates on clkEn; stage 2 shifts and saturates the dumped sum one clock later.
module au_decimator #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18,
  parameter int DEC_WIDTH = 15,
  parameter int ACC_WIDTH = IN_WIDTH + DEC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkEn,
  input  logic [IN_WIDTH-1:0]  dataIn,
  input  logic [DEC_WIDTH-1:0] auDecimation,
  input  logic [5:0]           auShift,
  output logic [OUT_WIDTH-1:0] dataOut,
  output logic                 dataValid,
  output logic                 satFlag
);

  localparam int EXT_W = ACC_WIDTH - IN_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] MAX_POS =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MAX_NEG =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [DEC_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        dump_pend_q, dump_pend_d;
  logic [OUT_WIDTH-1:0]        out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        sat_q, sat_d;

  logic [DEC_WIDTH-1:0]        nm1;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic [5:0]                  sh;
  logic signed [ACC_WIDTH-1:0] shifted;

  // Ratio 0 behaves as 1; >= lets a reduced ratio dump immediately instead of wrapping.
  assign nm1     = (auDecimation == '0) ? '0 : auDecimation - DEC_WIDTH'(1);
  assign in_ext  = {{EXT_W{dataIn[IN_WIDTH-1]}}, dataIn};
  assign sh      = (auShift > 6'(ACC_WIDTH)) ? 6'(ACC_WIDTH) : auShift;
  assign shifted = sum_q >>> sh;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    dump_pend_d = 1'b0;
    if (clkEn) begin
      if (cnt_q >= nm1) begin
        sum_d       = acc_q + in_ext;
        acc_d       = '0;
        cnt_d       = '0;
        dump_pend_d = 1'b1;
      end else begin
        acc_d = acc_q + in_ext;
        cnt_d = cnt_q + DEC_WIDTH'(1);
      end
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    if (dump_pend_q) begin
      valid_d = 1'b1;
      if (shifted > MAX_POS) begin
        out_d = OUT_POS;
        sat_d = 1'b1;
      end else if (shifted < MAX_NEG) begin
        out_d = OUT_NEG;
        sat_d = 1'b1;
      end else begin
        out_d = shifted[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      dump_pend_q <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      dump_pend_q <= dump_pend_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
    end
  end

  assign dataOut   = out_q;
  assign dataValid = valid_q;
  assign satFlag   = sat_q;

endmodule

// File: tb/tb_au_decimator.sv
// Directed bench for au_decimator: table of group-level vectors plus hand sequences
// for reset mid-group, ratio reduction mid-group and the maximum ratio.
module tb_au_decimator;

  localparam int IW = 18;
  localparam int OW = 18;
  localparam int DW = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clkEn;
  logic signed [IW-1:0] dataIn;
  logic [DW-1:0]        auDecimation;
  logic [5:0]           auShift;
  logic signed [OW-1:0] dataOut;
  logic                 dataValid;
  logic                 satFlag;

  int tests = 0;
  int fails = 0;

  // scoreboard entries are {sat, out}
  logic [OW:0] exp_q[$];

  typedef struct {
    logic [DW-1:0]        dec;
    logic [5:0]           sh;
    logic signed [IW-1:0] data;
    int                   period;
    int                   groups;
    bit                   ramp;
    logic signed [OW-1:0] exp_out;
    bit                   exp_sat;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  au_decimator dut (
    .clk(clk),
    .reset(reset),
    .clkEn(clkEn),
    .dataIn(dataIn),
    .auDecimation(auDecimation),
    .auShift(auShift),
    .dataOut(dataOut),
    .dataValid(dataValid),
    .satFlag(satFlag)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic en, input logic signed [IW-1:0] d);
    clkEn  = en;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, '0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check(input string name, input logic exp_v, input logic signed [OW-1:0] exp_o,
                       input logic exp_s, input logic cmp_out);
    logic ok;
    tests++;
    ok = (dataValid === exp_v) && (satFlag === exp_s) && (!(exp_v || cmp_out) || dataOut === exp_o);
    if (!ok) begin
      fails++;
      $display("FAIL %s: got valid=%0b out=%0d sat=%0b, want valid=%0b out=%0d sat=%0b",
               name, dataValid, dataOut, satFlag, exp_v, exp_o, exp_s);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int n, total, s;
    logic en, last;
    logic signed [IW-1:0] d;
    logic [OW:0] e;
    v = vecs[idx];
    n = (v.dec == '0) ? 1 : int'(v.dec);
    total = v.groups * n * v.period;
    do_reset();
    auDecimation = v.dec;
    auShift      = v.sh;
    s = 0;
    for (int c = 0; c < total + 2; c++) begin
      en   = (c < total) && (c % v.period == 0);
      d    = v.ramp ? IW'(s) : v.data;
      last = en && ((s + 1) % n == 0);
      cycle(en, d);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d c%0d", idx, c), 1'b1, e[OW-1:0], e[OW], 1'b0);
      end else begin
        check($sformatf("vec%0d c%0d", idx, c), 1'b0, '0, 1'b0, 1'b0);
      end
      if (last) exp_q.push_back({v.exp_sat, (v.ramp ? d : v.exp_out)});
      if (en) s++;
    end
  endtask

  initial begin
    int extra;
    reset = 1'b1; clkEn = 1'b0; dataIn = '0; auDecimation = 15'd4; auShift = 6'd2;

    //            dec     sh    data         per grp ramp exp_out       sat
    vecs[0] = '{15'd4,    6'd2, 18'sd1000,    1, 3,  1'b0, 18'sd1000,    1'b0};
    vecs[1] = '{15'd4,    6'd2, -18'sd1000,   3, 2,  1'b0, -18'sd1000,   1'b0};
    vecs[2] = '{15'd0,    6'd0, 18'sd0,       1, 21, 1'b1, 18'sd0,       1'b0};
    vecs[3] = '{15'd1,    6'd0, 18'sd0,       1, 21, 1'b1, 18'sd0,       1'b0};
    vecs[4] = '{15'd2,    6'd0, 18'sd131071,  1, 2,  1'b0, 18'sd131071,  1'b1};
    vecs[5] = '{15'd2,    6'd0, -18'sd131072, 1, 2,  1'b0, -18'sd131072, 1'b1};
    vecs[6] = '{15'd2,    6'd50, -18'sd131072,1, 2,  1'b0, -18'sd1,      1'b0};
    vecs[7] = '{15'd2,    6'd33, -18'sd131072,1, 2,  1'b0, -18'sd1,      1'b0};
    vecs[8] = '{15'd3,    6'd1, 18'sd7,       2, 2,  1'b0, 18'sd10,      1'b0};
    vecs[9] = '{15'd3,    6'd1, -18'sd7,      1, 2,  1'b0, -18'sd11,     1'b0};

    cycle(1'b0, '0);
    cycle(1'b0, '0);
    check("reset state", 1'b0, '0, 1'b0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset after 2 of 4 samples discards the partial sum and clears the output.
    do_reset();
    auDecimation = 15'd4; auShift = 6'd2;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 18'sd800);
      check($sformatf("rst pre s%0d", i), 1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b0, '0);
    check("rst pre out", 1'b1, 18'sd800, 1'b0, 1'b1);
    cycle(1'b0, '0);
    check("rst hold out", 1'b0, 18'sd800, 1'b0, 1'b1);
    cycle(1'b1, 18'sd500);
    cycle(1'b1, 18'sd500);
    reset = 1'b1;
    cycle(1'b0, '0);
    reset = 1'b0;
    check("rst cleared", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 18'sd500);
      check($sformatf("rst post s%0d", i), 1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b0, '0);
    check("rst post out", 1'b1, 18'sd500, 1'b0, 1'b1);

    // Ratio reduced from 100 to 4 after 50 samples: dump on the next sample.
    do_reset();
    auDecimation = 15'd100; auShift = 6'd0;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 18'sd1);
      if (dataValid !== 1'b0) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ratio early valid: got %0d pulses, want 0", extra);
    end
    auDecimation = 15'd4;
    cycle(1'b1, 18'sd1);
    check("ratio s51", 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 18'sd1);
    check("ratio out51", 1'b1, 18'sd51, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 18'sd1);
      check($sformatf("ratio g1 s%0d", i + 2), 1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b1, 18'sd1);
    check("ratio out4", 1'b1, 18'sd4, 1'b0, 1'b1);
    cycle(1'b0, '0);
    check("ratio idle", 1'b0, 18'sd4, 1'b0, 1'b1);

    // Maximum ratio: floor(131071*32767/32768) = 131067, no saturation.
    do_reset();
    auDecimation = 15'd32767; auShift = 6'd15;
    extra = 0;
    for (int i = 0; i < 32767; i++) begin
      cycle(1'b1, 18'sd131071);
      if (dataValid !== 1'b0) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL maxratio early valid: got %0d pulses, want 0", extra);
    end
    cycle(1'b0, '0);
    check("maxratio out", 1'b1, 18'sd131067, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/au_decimator.md
Name: au_decimator

Overview:
- Integrate-and-dump decimator on the audio path, directly downstream of the resampler register bank.
- Consumes the AU decimation count and AU shift register fields.
- Sums N consecutive input samples, right-shifts the sum by a programmable amount, saturates it and emits one output per N inputs.
- Sits between the audio resampler output and the audio DAC/FIFO interface.

Parameters:
- IN_WIDTH, 18, signed input sample width.
- OUT_WIDTH, 18, signed output sample width.
- DEC_WIDTH, 15, width of the decimation control (matches the AU decimation register field).
- ACC_WIDTH, IN_WIDTH+DEC_WIDTH (33), accumulator width; sized so the sum never overflows.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- clkEn  input  1  input sample strobe; one sample per clk with clkEn high.
- dataIn  input  IN_WIDTH  signed input sample, valid when clkEn=1.
- auDecimation  input  DEC_WIDTH  decimation ratio N, unsigned; 0 is treated as 1.
- auShift  input  6  arithmetic right-shift applied to the sum; values above ACC_WIDTH are clamped to ACC_WIDTH.
- dataOut  output  OUT_WIDTH  signed decimated sample; held between updates.
- dataValid  output  1  one-clk pulse when dataOut updates.
- satFlag  output  1  one-clk pulse coincident with dataValid when the output saturated.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: acc=0, cnt=0, sumReg=0, dumpPend=0, dataOut=0, dataValid=0, satFlag=0.
- Reset mid-accumulation discards the partial sum. No output is produced for the discarded samples.
- Effective ratio: Nm1 = (auDecimation==0) ? 0 : auDecimation-1.
- Stage 1 acts on clk with clkEn=1:
  - If cnt >= Nm1 (dump): sumReg <= acc + sext(dataIn); acc <= 0; cnt <= 0; dumpPend <= 1.
  - Otherwise: acc <= acc + sext(dataIn); cnt <= cnt+1.
- clkEn=0: acc and cnt hold; dumpPend <= 0.
- Stage 2 acts on clk with dumpPend=1:
  - sh = min(auShift, ACC_WIDTH); t = sumReg >>> sh (arithmetic).
  - If t > 2^(OUT_WIDTH-1)-1: dataOut <= max positive, satFlag <= 1.
  - If t < -2^(OUT_WIDTH-1): dataOut <= max negative, satFlag <= 1.
  - Otherwise: dataOut <= t[OUT_WIDTH-1:0], satFlag <= 0.
  - dataValid <= 1.
- When dumpPend=0: dataValid <= 0, satFlag <= 0, dataOut holds.
- Latency: the last sample of a group is presented with clkEn at edge k. dataOut/dataValid are visible after edge k+1. That is 2 clk from the sample to the registered output.
- Back-to-back clkEn is supported. With N=1, dataValid may be high on consecutive clks.
- Using `>=` rather than `==` in the dump compare means a reduced auDecimation takes effect on the next clkEn, with no wrap through 2^DEC_WIDTH. An increase extends the current group.
- auShift is sampled in stage 2, so a change applies to the next dump output.
- No truncation of the sum: accumulator overflow is impossible by sizing. Rounding is by truncation (floor from the arithmetic shift).
- Control inputs come from a register bank written on a slower bus strobe. They are treated as quasi-static, and no synchronisers are inside this block.

Test Plan:
- auDecimation=4, auShift=2, dataIn=+1000 constant, clkEn every clk -> dataOut=1000, dataValid every 4th clk, satFlag=0. The first dataValid is 2 clk after the 4th sample.
- auDecimation=4, auShift=2, dataIn=-1000 with clkEn every 3rd clk -> dataOut=-1000 every 12 clk. Checks that the accumulator holds while clkEn=0 and that the shift is arithmetic.
- auDecimation=0 and auDecimation=1, auShift=0, ramp 0..20 every clk -> dataOut equals dataIn delayed 2 clk, dataValid continuously high.
- auDecimation=32767, auShift=0, dataIn=+131071 -> dataOut=131071, satFlag=1. Repeat with auShift=15 -> dataOut=131067 (floor of 131071*32767/32768), satFlag=0.
  - With dataIn=-131072 and auShift=0 -> dataOut=-131072, satFlag=1.
  - With auShift=50 -> same result as auShift=33: dataOut=-1.
- auDecimation=100, change to 4 after 50 samples -> dump on the next clkEn (51-sample sum). Subsequent groups contain 4 samples.
- Assert reset for one clk after 2 of 4 samples (dataIn=500) -> dataOut=0, dataValid=0. The next output appears after 4 fresh samples and equals 500 (auShift=2).
